// File: rtl/lc3_mem_pkg.sv
// lc3_mem_pkg
// Shared definitions for the LC-3 memory responder.
// Contents:
//   state_t      - responder FSM states (IDLE / WAIT / DONE)
//   LC3_DATA_W   - LC-3 bus width
//   MMIO_BASE    - first address of the memory-mapped I/O page
//   *_ADDR       - keyboard and display register addresses
package lc3_mem_pkg;

  localparam int LC3_DATA_W = 16;

  localparam logic [15:0] MMIO_BASE = 16'hFE00;
  localparam logic [15:0] KBSR_ADDR = 16'hFE00;
  localparam logic [15:0] KBDR_ADDR = 16'hFE02;
  localparam logic [15:0] DSR_ADDR  = 16'hFE04;
  localparam logic [15:0] DDR_ADDR  = 16'hFE06;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/lc3_mem_array.sv
// lc3_mem_array
// Word-addressed backing store for the LC-3 responder. Contents are not
// reset, so they survive an rst_n pulse.
// Ports:
//   clk    - system clock, rising edge
//   we     - write enable, sampled on the rising edge
//   addr   - word index
//   wdata  - write data
//   rdata  - asynchronous read data at addr
module lc3_mem_array
  import lc3_mem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int WIDTH = LC3_DATA_W,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/lc3_mem_responder.sv
// lc3_mem_responder
// Memory-side responder for the LC-3 MAR/MDR bus. A request is captured in
// IDLE, waits a fixed LATENCY, then commits and pulses r for one cycle.
// Addresses below xFE00 go to the backing array; xFE00-xFE06 are the
// keyboard/display registers, other I/O addresses read as zero.
// Ports:
//   clk, rst_n        - clock (rising edge), async active-low reset
//   mio_en, r_w       - request valid (sampled in IDLE), 1 = write
//   mar, mdr_in       - word address and write data
//   mem_out, r        - read data (valid while r = 1, held otherwise), ready pulse
//   kb_data, kb_valid - keyboard character and one-cycle strobe
//   disp_ready        - display can accept a character
//   disp_data         - display character
//   disp_valid        - one-cycle display strobe, coincident with r
module lc3_mem_responder
  import lc3_mem_pkg::*;
#(
  parameter int LATENCY   = 3,
  parameter int MEM_DEPTH = 1024,
  parameter int DATA_W    = LC3_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mio_en,
  input  logic              r_w,
  input  logic [DATA_W-1:0] mar,
  input  logic [DATA_W-1:0] mdr_in,
  output logic [DATA_W-1:0] mem_out,
  output logic              r,
  input  logic [7:0]        kb_data,
  input  logic              kb_valid,
  input  logic              disp_ready,
  output logic [7:0]        disp_data,
  output logic              disp_valid
);

  localparam int AW    = $clog2(MEM_DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  if (LATENCY < 1) begin : g_bad_latency
    $error("lc3_mem_responder: LATENCY must be >= 1");
  end
  if ((MEM_DEPTH < 2) || ((MEM_DEPTH & (MEM_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("lc3_mem_responder: MEM_DEPTH must be a power of two");
  end
  if (DATA_W != LC3_DATA_W) begin : g_bad_width
    $error("lc3_mem_responder: DATA_W must be 16");
  end

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              write_q;
  logic              kb_full;
  logic [7:0]        kb_char;

  logic              commit;
  logic              is_array;
  logic              array_we;
  logic              kbdr_read;
  logic [DATA_W-1:0] array_rdata;
  logic [DATA_W-1:0] read_data;

  // The edge that moves WAIT -> DONE is the single commit point for both
  // array writes and MMIO side effects.
  assign commit    = (state == WAIT) && (cnt == '0);
  assign is_array  = (addr_q < MMIO_BASE);
  assign array_we  = commit && write_q && is_array;
  assign kbdr_read = commit && !write_q && (addr_q == KBDR_ADDR);

  lc3_mem_array #(
    .DEPTH (MEM_DEPTH),
    .WIDTH (DATA_W),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .we    (array_we),
    .addr  (addr_q[AW-1:0]),
    .wdata (wdata_q),
    .rdata (array_rdata)
  );

  always_comb begin
    read_data = '0;
    if (is_array) begin
      read_data = array_rdata;
    end else begin
      case (addr_q)
        KBSR_ADDR: read_data = {kb_full, 15'b0};
        KBDR_ADDR: read_data = {8'b0, kb_char};
        DSR_ADDR:  read_data = {disp_ready, 15'b0};
        DDR_ADDR:  read_data = {8'b0, disp_data};
        default:   read_data = '0;
      endcase
    end
  end

  // A new keystroke wins over the KBDR read clear on the same edge, so the
  // reader gets the old character and the new one stays pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kb_full <= 1'b0;
      kb_char <= '0;
    end else if (kb_valid) begin
      kb_full <= 1'b1;
      kb_char <= kb_data;
    end else if (kbdr_read) begin
      kb_full <= 1'b0;
    end
  end

  // With LATENCY = 1 the counter loads 0, so WAIT lasts one cycle and r
  // still rises exactly LATENCY edges after the sample edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      write_q    <= 1'b0;
      r          <= 1'b0;
      mem_out    <= '0;
      disp_data  <= '0;
      disp_valid <= 1'b0;
    end else begin
      r          <= 1'b0;
      disp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (mio_en) begin
            addr_q  <= mar;
            wdata_q <= mdr_in;
            write_q <= r_w;
            cnt     <= CNT_LOAD;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state <= DONE;
            r     <= 1'b1;
            if (!write_q) begin
              mem_out <= read_data;
            end else if (addr_q == DDR_ADDR) begin
              disp_data  <= wdata_q[7:0];
              disp_valid <= 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
